// File: rtl/button_conditioner.sv
// N-channel push-button front end: synchroniser, debouncer and press/release/repeat pulse FSM.
// Each channel is independent; pulses are registered and exactly one cycle wide.
module button_conditioner #(
  parameter int N_BTN         = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 3125000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             REL_VAL  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic                   level_q, level_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    state_t                 state_q, state_d;
    logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   rise, fall;

    // Polarity is normalised in the flop after the chain so s_q is always 1 = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{REL_VAL}};
        s_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
        s_q    <= sync_q[SYNC_STAGES-1] ^ REL_VAL;
      end
    end

    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      rise     = 1'b0;
      fall     = 1'b0;
      if (s_q != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = s_q;
          rise    = s_q;
          fall    = ~s_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          rpt_cnt_d = '0;
          if (rise) begin
            state_d = ST_HELD;
            press_d = enable;
          end
        end
        default: begin
          // A release always wins over a repeat that falls due in the same cycle.
          if (fall) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
            release_d = enable;
          end else if (!enable || !repeat_en[i]) begin
            state_d   = ST_HELD;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == ((state_q == ST_HELD) ? DLY_LAST : PER_LAST)) begin
            state_d   = ST_REPEAT;
            rpt_cnt_d = '0;
            press_d   = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q   <= 1'b0;
        db_cnt_q  <= '0;
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= level_d;
        db_cnt_q  <= db_cnt_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule
